// File: rtl/seq_divrem_pkg.sv
// Shared types and helpers for the sequential sign-magnitude divider.
// Holds the FSM state encoding, the packed result-flag bundle and sm_norm().
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } divrem_state_e;

   typedef struct packed {
      logic zerF;
      logic negF;
      logic DZF;
   } divrem_flags_t;

   // Returns the sign bit to store for a magnitude: a zero magnitude
   // never carries a set sign bit, so there is no negative zero.
   function automatic logic sm_norm(input logic sign,
                                    input logic [31:0] mag);
      return sign & (|mag);
   endfunction

endpackage

// File: rtl/seq_divrem_if.sv
// Start/busy/done handshake and operand/result bundle of seq_divrem.
// master: start, NumA, NumB out; slave: busy, done, Quo, Res, flags out.
interface seq_divrem_if #(
   parameter int MAG_W = 2
);
   logic             start;
   logic [MAG_W:0]   NumA;
   logic [MAG_W:0]   NumB;
   logic             busy;
   logic             done;
   logic [MAG_W:0]   Quo;
   logic [MAG_W:0]   Res;
   logic             zerF;
   logic             negF;
   logic             DZF;

   modport master (
      output start, NumA, NumB,
      input  busy, done, Quo, Res, zerF, negF, DZF
   );

   modport slave (
      input  start, NumA, NumB,
      output busy, done, Quo, Res, zerF, negF, DZF
   );
endinterface

// File: rtl/seq_divrem_step.sv
// One restoring-division iteration: shift in a dividend bit, trial
// subtract. Ports: rem_i, bit_i, div_i in; rem_o, q_o out.
module divrem_step #(
   parameter int W = 2
) (
   input  logic [W:0]   rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] div_i,
   output logic [W:0]   rem_o,
   output logic         q_o
);
   logic [W+1:0] sh;
   logic [W+1:0] diff;

   always_comb begin
      sh    = {rem_i, bit_i};
      diff  = sh - {2'b00, div_i};
      q_o   = (sh >= {2'b00, div_i});
      // remainder stays below the divisor, so W+1 bits always suffice
      rem_o = (W+1)'(q_o ? diff : sh);
   end
endmodule

// File: rtl/seq_divrem.sv
// Multi-cycle sign-magnitude divider: quotient, remainder, zer/neg/DZ flags.
// Ports: clk, rst (async high), bus (seq_divrem_if.slave). Option: DIVREM_EARLY_EXIT_EN.
module seq_divrem
   import alu_pkg::*;
#(
   parameter int MAG_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   seq_divrem_if.slave bus
);
   localparam int CW = $clog2(MAG_W);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_CALC = CALC;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]       state_q, state_d;
   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // dividend shifts out MSB-first while quotient bits shift in at LSB
   logic [MAG_W-1:0] a_q, a_d;
   logic [MAG_W-1:0] b_q, b_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [MAG_W:0]   rem_q, rem_d;
   logic [MAG_W:0]   quo_q, quo_d;
   logic [MAG_W:0]   res_q, res_d;
   divrem_flags_t    flg_q, flg_d;

   logic [MAG_W:0]   step_rem;
   logic             step_q;
   logic [MAG_W-1:0] quo_n;
   logic [MAG_W-1:0] rmag;
   logic             rsgn;

   divrem_step #(.W(MAG_W)) u_step (
      .rem_i (rem_q),
      .bit_i (a_q[MAG_W-1]),
      .div_i (b_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_comb begin
      quo_n = {a_q[MAG_W-2:0], step_q};
      rmag  = step_rem[MAG_W-1:0];
      rsgn  = sm_norm(sa_q, 32'(rmag));
   end

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      flg_d   = flg_q;
      unique case (state_q)
         S_IDLE: begin
            if (!busy_q) begin
               if (bus.start) begin
                  busy_d = 1'b1;
                  a_d    = bus.NumA[MAG_W-1:0];
                  b_d    = bus.NumB[MAG_W-1:0];
                  sa_d   = bus.NumA[MAG_W];
                  sb_d   = bus.NumB[MAG_W];
               end
            end else if (b_q == '0) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               quo_d   = '0;
               res_d   = '0;
               flg_d   = '{zerF: 1'b1, negF: 1'b0, DZF: 1'b1};
`ifdef DIVREM_EARLY_EXIT_EN
            end else if (a_q < b_q) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               quo_d   = '0;
               res_d   = {sm_norm(sa_q, 32'(a_q)), a_q};
               flg_d   = '{zerF: (a_q == '0),
                           negF: sm_norm(sa_q, 32'(a_q)),
                           DZF:  1'b0};
`endif
            end else begin
               state_d = S_CALC;
               cnt_d   = CW'(MAG_W - 1);
               rem_d   = '0;
            end
         end
         S_CALC: begin
            a_d   = quo_n;
            rem_d = step_rem;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               quo_d   = {sm_norm(sa_q ^ sb_q, 32'(quo_n)), quo_n};
               res_d   = {rsgn, rmag};
               flg_d   = '{zerF: (rmag == '0), negF: rsgn,
                           DZF: 1'b0};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = (state_q == S_DONE);
   assign bus.Quo  = quo_q;
   assign bus.Res  = res_q;
   assign bus.zerF = flg_q.zerF;
   assign bus.negF = flg_q.negF;
   assign bus.DZF  = flg_q.DZF;
endmodule

// File: tb/tb_seq_divrem.sv
// Self-checking bench for seq_divrem at MAG_W=2 and MAG_W=8.
// Scoreboard queues hold expected results and latencies per operation.
module tb_seq_divrem;

   typedef struct packed {
      logic [8:0] quo;
      logic [8:0] res;
      logic       zer;
      logic       neg;
      logic       dz;
   } res_t;

   logic clk = 1'b0;
   logic rst2 = 1'b1;
   logic rst8 = 1'b1;
   int   total = 0;
   int   bad = 0;

   res_t exp_q[$];
   int   lat_q[$];

   always #5 clk = ~clk;

   seq_divrem_if #(.MAG_W(2)) b2 ();
   seq_divrem_if #(.MAG_W(8)) b8 ();

   seq_divrem #(.MAG_W(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(b2));
   seq_divrem #(.MAG_W(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(b8));

   function automatic res_t ref_model(int w, logic [8:0] a,
                                      logic [8:0] b);
      int unsigned m, am, bm, sa, sb, qm, rm;
      res_t r;
      m  = (32'd1 << w) - 1;
      am = a & m;
      bm = b & m;
      sa = (a >> w) & 1;
      sb = (b >> w) & 1;
      r  = '0;
      if (bm == 0) begin
         r.zer = 1'b1;
         r.dz  = 1'b1;
         return r;
      end
      qm = am / bm;
      rm = am % bm;
      r.quo = 9'(((((sa ^ sb) != 0) && qm != 0) ? (1 << w) : 0) | qm);
      r.res = 9'(((sa != 0 && rm != 0) ? (1 << w) : 0) | rm);
      r.zer = (rm == 0);
      r.neg = (sa != 0 && rm != 0);
      return r;
   endfunction

   function automatic int ref_lat(int w, logic [8:0] a, logic [8:0] b);
      int unsigned m;
      m = (32'd1 << w) - 1;
      if ((b & m) == 0) return 1;
`ifdef DIVREM_EARLY_EXIT_EN
      if ((a & m) < (b & m)) return 1;
`endif
      return w + 1;
   endfunction

   task automatic run_op(input int w, input logic [8:0] a,
                         input logic [8:0] b, output res_t o,
                         output int lat);
      @(posedge clk);
      @(negedge clk);
      if (w == 8) begin
         b8.NumA = a;
         b8.NumB = b;
         b8.start = 1'b1;
      end else begin
         b2.NumA = a[2:0];
         b2.NumB = b[2:0];
         b2.start = 1'b1;
      end
      @(posedge clk);
      #1;
      b2.start = 1'b0;
      b8.start = 1'b0;
      b2.NumA = 3'($urandom);
      b2.NumB = 3'($urandom);
      b8.NumA = 9'($urandom);
      b8.NumB = 9'($urandom);
      lat = 0;
      o = '0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         if ((w == 8) ? b8.done : b2.done) lat = k;
      end
      if (w == 8) begin
         o.quo = b8.Quo;
         o.res = b8.Res;
         o.zer = b8.zerF;
         o.neg = b8.negF;
         o.dz  = b8.DZF;
      end else begin
         o.quo = 9'(b2.Quo);
         o.res = 9'(b2.Res);
         o.zer = b2.zerF;
         o.neg = b2.negF;
         o.dz  = b2.DZF;
      end
   endtask

   task automatic test_reset;
      b2.start = 1'b0;
      b2.NumA = '0;
      b2.NumB = '0;
      b8.start = 1'b0;
      b8.NumA = '0;
      b8.NumB = '0;
      #3;
      total++;
      if ({b2.busy, b2.done, b2.Quo, b2.Res, b2.zerF, b2.negF, b2.DZF}
          !== '0) begin
         bad++;
         $display("FAIL reset_w2: got %b want 0",
                  {b2.busy, b2.done, b2.Quo, b2.Res,
                   b2.zerF, b2.negF, b2.DZF});
      end
      total++;
      if ({b8.busy, b8.done, b8.Quo, b8.Res, b8.zerF, b8.negF, b8.DZF}
          !== '0) begin
         bad++;
         $display("FAIL reset_w8: got %b want 0",
                  {b8.busy, b8.done, b8.Quo, b8.Res,
                   b8.zerF, b8.negF, b8.DZF});
      end
      @(negedge clk);
      rst2 = 1'b0;
      rst8 = 1'b0;
   endtask

   task automatic test_vectors;
      // a, b, quo, res, zer, neg, dz, latency
      logic [2:0] va[5] = '{3'b011, 3'b111, 3'b110, 3'b011, 3'b011};
      logic [2:0] vb[5] = '{3'b010, 3'b010, 3'b001, 3'b100, 3'b010};
      logic [2:0] vq[5] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b001};
      logic [2:0] vr[5] = '{3'b001, 3'b101, 3'b000, 3'b000, 3'b001};
      logic [2:0] vf[5] = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b000};
      int         vl[5] = '{3, 3, 3, 1, 3};
      res_t o, e;
      int   lat, el;
      for (int i = 0; i < 5; i++) begin
         e = '0;
         e.quo = 9'(vq[i]);
         e.res = 9'(vr[i]);
         {e.zer, e.neg, e.dz} = vf[i];
         exp_q.push_back(e);
         lat_q.push_back(vl[i]);
         run_op(2, 9'(va[i]), 9'(vb[i]), o, lat);
         e = exp_q.pop_front();
         el = lat_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL vec%0d_result: got %h want %h", i, o, e);
         end
         total++;
         if (lat !== el) begin
            bad++;
            $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, el);
         end
      end
   endtask

   task automatic test_abort;
      res_t o, e;
      int   lat, el, seen;
      exp_q.push_back(ref_model(8, 9'd200, 9'd3));
      lat_q.push_back(ref_lat(8, 9'd200, 9'd3));
      run_op(8, 9'd200, 9'd3, o, lat);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      total++;
      if (o !== e || lat !== el) begin
         bad++;
         $display("FAIL abort_prep: got %h/%0d want %h/%0d",
                  o, lat, e, el);
      end
      @(posedge clk);
      @(negedge clk);
      b8.NumA = 9'd250;
      b8.NumB = 9'd7;
      b8.start = 1'b1;
      @(posedge clk);
      #1;
      b8.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (b8.busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_busy: got %b want 1", b8.busy);
      end
      rst8 = 1'b1;
      #1;
      total++;
      if ({b8.busy, b8.done, b8.Quo, b8.Res, b8.zerF, b8.negF, b8.DZF}
          !== '0) begin
         bad++;
         $display("FAIL abort_clear: got %b want 0",
                  {b8.busy, b8.done, b8.Quo, b8.Res,
                   b8.zerF, b8.negF, b8.DZF});
      end
      @(negedge clk);
      rst8 = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (b8.done) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL abort_nodone: got %0d want 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      res_t o, e;
      int   lat, el, seen;
      exp_q.push_back(ref_model(8, 9'd77, 9'd5));
      lat_q.push_back(ref_lat(8, 9'd77, 9'd5));
      @(posedge clk);
      @(negedge clk);
      b8.NumA = 9'd77;
      b8.NumB = 9'd5;
      b8.start = 1'b1;
      @(posedge clk);
      #1;
      b8.start = 1'b0;
      @(negedge clk);
      b8.NumA = 9'd9;
      b8.NumB = 9'd3;
      b8.start = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         b8.start = 1'b0;
         if (b8.done) lat = k;
      end
      o.quo = b8.Quo;
      o.res = b8.Res;
      o.zer = b8.zerF;
      o.neg = b8.negF;
      o.dz  = b8.DZF;
      // another start held across the done cycle must also be dropped
      b8.start = 1'b1;
      @(posedge clk);
      #1;
      b8.start = 1'b0;
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL b2b_result: got %h want %h", o, e);
      end
      total++;
      if (lat !== el) begin
         bad++;
         $display("FAIL b2b_latency: got %0d want %0d", lat, el);
      end
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (b8.done) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL b2b_extra_done: got %0d want 0", seen);
      end
   endtask

   task automatic test_random;
      res_t o, e;
      int   lat, el;
      logic [8:0] a, b;
      for (int i = 0; i < 3000; i++) begin
         a = 9'($urandom);
         b = 9'($urandom);
         case ($urandom_range(0, 7))
            0: b[7:0] = 8'd0;
            1: b[7:0] = 8'($urandom_range(1, 4));
            2: a[7:0] = 8'd0;
            default: ;
         endcase
         exp_q.push_back(ref_model(8, a, b));
         lat_q.push_back(ref_lat(8, a, b));
         run_op(8, a, b, o, lat);
         e = exp_q.pop_front();
         el = lat_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL rand%0d_result a=%h b=%h: got %h want %h",
                     i, a, b, o, e);
         end
         total++;
         if (lat !== el) begin
            bad++;
            $display("FAIL rand%0d_latency: got %0d want %0d",
                     i, lat, el);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_abort();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
